// File: rtl/shift_sequencer.sv
// Multi-position logical shifter that iterates a one-bit registered shift unit.
// Optional macro SHIFT_SEQ_FASTZERO_EN: amounts >= WIDTH complete at once with a zero result.
module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [AMT_W-1:0] req_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic [WIDTH-1:0] su_a,
    output logic [WIDTH-1:0] su_b,
    output logic [1:0]       su_fun,
    output logic             su_enable,
    input  logic [WIDTH-1:0] su_out,
    input  logic             su_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             req_ready_q, resp_valid_q, busy_q, su_enable_q;
    logic [WIDTH-1:0] su_a_q, su_a_d;
    logic [1:0]       su_fun_q, su_fun_d;

    // Next-state and datapath selection
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    work_d = req_data;
                    dir_d  = req_dir;
                    cnt_d  = req_amt;
                    if (req_amt == '0) begin
                        state_d     = ST_DONE;
                        resp_data_d = req_data;
                    end
`ifdef SHIFT_SEQ_FASTZERO_EN
                    else if (32'(req_amt) >= WIDTH) begin
                        state_d     = ST_DONE;
                        resp_data_d = '0;
                    end
`endif
                    else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Stay here until the shift unit reports, whatever its latency
                if (su_flag) begin
                    work_d = su_out;
                    cnt_d  = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d     = ST_DONE;
                        resp_data_d = su_out;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (resp_valid_q && resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift-unit operands only change on entry to ISSUE
    always_comb begin
        su_a_d   = su_a_q;
        su_fun_d = su_fun_q;
        if (state_d == ST_ISSUE) begin
            su_a_d   = work_d;
            su_fun_d = {1'b0, dir_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            su_enable_q  <= 1'b0;
            su_a_q       <= '0;
            su_fun_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_DONE);
            busy_q       <= (state_d != ST_IDLE);
            su_enable_q  <= (state_d == ST_ISSUE);
            su_a_q       <= su_a_d;
            su_fun_q     <= su_fun_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;
    assign su_enable  = su_enable_q;
    assign su_a       = su_a_q;
    assign su_fun     = su_fun_q;
    assign su_b       = '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer with a variable-latency shift-unit model.
module tb_shift_sequencer;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 5;
`ifdef SHIFT_SEQ_FASTZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             req_dir;
    logic [AMT_W-1:0] req_amt;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             busy;
    logic [WIDTH-1:0] su_a;
    logic [WIDTH-1:0] su_b;
    logic [1:0]       su_fun;
    logic             su_enable;
    logic [WIDTH-1:0] su_out;
    logic             su_flag;

    int n_checks = 0;
    int n_errors = 0;
    int su_lat   = 1;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_dir(req_dir), .req_amt(req_amt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .su_a(su_a), .su_b(su_b), .su_fun(su_fun),
        .su_enable(su_enable), .su_out(su_out), .su_flag(su_flag)
    );

    always #5 clk = ~clk;

    // Shift-unit model: one-bit shift, flag pulses su_lat cycles after enable
    logic [WIDTH-1:0] pipe_d [4];
    logic             pipe_v [4];
    always @(posedge clk) begin
        pipe_v[0] <= su_enable;
        pipe_d[0] <= (su_fun == 2'b01) ? (su_a << 1) : (su_a >> 1);
        for (int i = 1; i < 4; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign su_flag = pipe_v[su_lat-1];
    assign su_out  = pipe_d[su_lat-1];

    // Record every issued shift operation
    logic [WIDTH-1:0] pulse_a[$];
    logic [1:0]       pulse_fun[$];
    always @(negedge clk) begin
        if (su_enable) begin
            pulse_a.push_back(su_a);
            pulse_fun.push_back(su_fun);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input bit dir, input int n);
        if (n >= int'(WIDTH)) return '0;
        return dir ? (d << n) : (d >> n);
    endfunction

    task automatic do_txn(input logic [WIDTH-1:0] d, input bit dir, input int amt,
                          input int hold, input int lat);
        int k;
        int exp_k;
        int exp_pulses;
        logic [WIDTH-1:0] held;
        bit fast_case;
        su_lat = lat;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        pulse_a.delete();
        pulse_fun.delete();
        req_valid = 1'b1; req_data = d; req_dir = dir; req_amt = AMT_W'(amt);
        @(posedge clk); #1;
        req_valid = 1'b0;
        fast_case  = FAST && (amt >= int'(WIDTH));
        exp_k      = (amt == 0 || fast_case) ? 0 : amt * (1 + lat);
        exp_pulses = fast_case ? 0 : amt;
        k = 0;
        while (!resp_valid && k < 400) begin
            @(posedge clk); #1; k++;
        end
        check_eq("resp_valid_seen", 32'(resp_valid), 32'd1);
        check_eq("latency", 32'(k), 32'(exp_k));
        check_eq("resp_data", 32'(resp_data), 32'(ref_shift(d, dir, amt)));
        check_eq("busy_done", 32'(busy), 32'd1);
        check_eq("req_ready_done", 32'(req_ready), 32'd0);
        check_eq("su_b_zero", 32'(su_b), 32'd0);
        check_eq("pulse_count", 32'(pulse_a.size()), 32'(exp_pulses));
        for (int i = 0; i < pulse_a.size() && i < exp_pulses; i++) begin
            check_eq("pulse_su_a", 32'(pulse_a[i]), 32'(ref_shift(d, dir, i)));
            check_eq("pulse_su_fun", 32'(pulse_fun[i]), 32'({1'b0, dir}));
        end
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_data", 32'(resp_data), 32'(held));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_eq("resp_valid_drop", 32'(resp_valid), 32'd0);
        check_eq("idle_req_ready", 32'(req_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_data = '0; req_dir = 1'b0;
        req_amt = '0; resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0; pipe_d[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_data", 32'(resp_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_su_enable", 32'(su_enable), 32'd0);
        check_eq("rst_su_a", 32'(su_a), 32'd0);
        check_eq("rst_su_fun", 32'(su_fun), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_txn(16'hB3C4, 1'b0, 3, 0, 1);
        do_txn(16'h00F1, 1'b1, 4, 0, 1);
        do_txn(16'hABCD, 1'b0, 0, 0, 1);
        do_txn(16'h8001, 1'b1, 1, 5, 1);
        do_txn(16'hFFFF, 1'b0, 20, 0, 1);
        do_txn(16'h0100, 1'b0, 2, 0, 3);

        // Reset in the middle of an amt=7 transaction
        su_lat = 1;
        req_valid = 1'b1; req_data = 16'h1234; req_dir = 1'b1; req_amt = AMT_W'(7);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_su_enable", 32'(su_enable), 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        do_txn(16'h0F0F, 1'b0, 5, 1, 1);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            do_txn(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
